// File: rtl/fas_ctrl.sv
// fas_ctrl: sequences FIR samples into a ping-pong FFT input buffer, launches FFT frames and tracks run completion.
// Optional frequency-analysis stage after the last frame is enabled by defining FAS_CTRL_ANALYSIS_EN.
module fas_ctrl #(
    parameter int NUM_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fir_valid,
    output logic       buf_wr,
    output logic       buf_bank,
    output logic [3:0] buf_addr,
    output logic       fft_start,
    output logic       fft_bank,
    input  logic       fft_done,
    output logic       fft_valid,
    output logic [6:0] frame_cnt,
    output logic       ana_start,
    input  logic       ana_done,
    output logic       done,
    output logic       overrun
);

    localparam logic [10:0] TOTAL_SAMPLES = 11'(NUM_FRAMES * 16);
    localparam logic [6:0]  LAST_FRAME    = 7'(NUM_FRAMES);

    typedef enum logic [1:0] {
        ST_STREAM  = 2'd0,
        ST_ANALYZE = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] acc_cnt_q, acc_cnt_d;
    logic        wr_bank_q, wr_bank_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [1:0]  full_q, full_d;
    logic        busy_q, busy_d;
    logic        fft_bank_q, fft_bank_d;
    logic        next_bank_q, next_bank_d;
    logic        fft_start_q, fft_start_d;
    logic        fft_valid_q, fft_valid_d;
    logic [6:0]  frame_cnt_q, frame_cnt_d;
    logic        ana_start_q, ana_start_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic sample_ok;
    logic wr_en;
    logic drop;
    logic done_acc;
    logic launch;

    // A sample is a candidate only while streaming and below the run length; reset gates the strobe directly.
    assign sample_ok = rst && fir_valid && (state_q == ST_STREAM) && (acc_cnt_q < TOTAL_SAMPLES);
    assign wr_en     = sample_ok && !full_q[wr_bank_q];
    assign drop      = sample_ok &&  full_q[wr_bank_q];
    assign done_acc  = fft_done && busy_q;

`ifndef FAS_CTRL_ANALYSIS_EN
    logic unused_ana;
    assign unused_ana = ana_done;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        full_d      = full_q;
        busy_d      = busy_q;
        fft_bank_d  = fft_bank_q;
        next_bank_d = next_bank_q;
        fft_start_d = 1'b0;
        fft_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        ana_start_d = 1'b0;
        done_d      = done_q;
        overrun_d   = overrun_q;
        launch      = 1'b0;

        if (wr_en) begin
            acc_cnt_d = acc_cnt_q + 11'd1;
            wr_addr_d = wr_addr_q + 4'd1;
            if (wr_addr_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        if (drop) begin
            overrun_d = 1'b1;
        end

        if (done_acc) begin
            full_d[fft_bank_q] = 1'b0;
            busy_d             = 1'b0;
            fft_valid_d        = 1'b1;
            frame_cnt_d        = frame_cnt_q + 7'd1;
        end

        // Launch decision sees this edge's fill and release, so a coincident fill and fft_done both take effect.
        launch = full_d[next_bank_q] && !busy_d;
        if (launch) begin
            fft_start_d = 1'b1;
            fft_bank_d  = next_bank_q;
            next_bank_d = ~next_bank_q;
            busy_d      = 1'b1;
        end

        case (state_q)
            ST_STREAM: begin
                if (done_acc && (frame_cnt_d == LAST_FRAME)) begin
`ifdef FAS_CTRL_ANALYSIS_EN
                    state_d     = ST_ANALYZE;
                    ana_start_d = 1'b1;
`else
                    state_d     = ST_FINISH;
`endif
                end
            end
            ST_ANALYZE: begin
`ifdef FAS_CTRL_ANALYSIS_EN
                if (ana_done) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
`else
                state_d = ST_FINISH;
`endif
            end
            ST_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_STREAM;
            acc_cnt_q   <= '0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            full_q      <= '0;
            busy_q      <= 1'b0;
            fft_bank_q  <= 1'b0;
            next_bank_q <= 1'b0;
            fft_start_q <= 1'b0;
            fft_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            ana_start_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            fft_bank_q  <= fft_bank_d;
            next_bank_q <= next_bank_d;
            fft_start_q <= fft_start_d;
            fft_valid_q <= fft_valid_d;
            frame_cnt_q <= frame_cnt_d;
            ana_start_q <= ana_start_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign buf_wr    = wr_en;
    assign buf_bank  = wr_bank_q;
    assign buf_addr  = wr_addr_q;
    assign fft_start = fft_start_q;
    assign fft_bank  = fft_bank_q;
    assign fft_valid = fft_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign ana_start = ana_start_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/fas_ctrl.md
FAS_CTRL -- requirements
Module: fas_ctrl

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 64, meaning the number of 16-sample FFT frames per run (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port fir_valid, input, 1 bit: the FIR filter presents one output sample this cycle.
REQ-005 SHALL have port buf_wr, output, 1 bit: write strobe into the ping-pong FFT input buffer.
REQ-006 SHALL have port buf_bank, output, 1 bit: the buffer bank being filled.
REQ-007 SHALL have port buf_addr, output, 4 bits: the write index within buf_bank.
REQ-008 SHALL have port fft_start, output, 1 bit: a one-cycle pulse that starts the FFT on bank fft_bank.
REQ-009 SHALL have port fft_bank, output, 1 bit: the bank owned by the FFT engine.
REQ-010 SHALL have port fft_done, input, 1 bit: a one-cycle pulse from the FFT engine marking frame results ready.
REQ-011 SHALL have port fft_valid, output, 1 bit: a one-cycle pulse qualifying fft_d0..fft_d15 downstream.
REQ-012 SHALL have port frame_cnt, output, 7 bits: the number of frames completed.
REQ-013 SHALL have port ana_start, output, 1 bit: a one-cycle pulse that starts the frequency-analysis stage.
REQ-014 SHALL have port ana_done, input, 1 bit: the analysis stage has finished and freq is stable.
REQ-015 SHALL have port done, output, 1 bit: the run is complete; held high until reset.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag set when a FIR sample is dropped.

Function
REQ-017 SHALL implement the top-level states STREAM, ANALYZE and FINISH; reset enters STREAM.
REQ-018 SHALL drive buf_wr combinationally as fir_valid AND STREAM AND (accepted samples < NUM_FRAMES*16) AND the fill bank is not full.
REQ-019 SHALL increment buf_addr on each write; a write at address 15 marks the bank full, toggles buf_bank and wraps buf_addr to 0 at the same edge.
REQ-020 SHALL track up to two full banks; each bank is full from its 16th write until the fft_done of the frame using it.
REQ-021 SHALL pulse fft_start the cycle after a bank becomes full if the FFT is idle; if the FFT is busy, SHALL pulse fft_start the cycle after fft_done; fft_bank is valid while fft_start is high and held until the next fft_start.
REQ-022 SHALL treat the FFT as busy from fft_start up to and including the cycle of fft_done; an fft_done while idle SHALL be ignored.
REQ-023 SHALL pulse fft_valid exactly one cycle after each accepted fft_done and increment frame_cnt on the same edge.
REQ-024 SHALL, when fir_valid is high in STREAM with both banks full, drop the sample (buf_wr=0), leave the pointer unchanged and set overrun.
REQ-025 SHALL ignore fir_valid once NUM_FRAMES*16 samples have been accepted; this does not set overrun.
REQ-026 SHALL, when a bank fill completes in the same cycle as fft_done, handle both events: the freed bank is released and the new full bank is queued, with no sample lost.
REQ-027 SHALL leave STREAM on the edge where frame_cnt reaches NUM_FRAMES, with the next state as defined under Configuration.

Reset
REQ-028 SHALL, with rst low, asynchronously force all outputs to 0, including buf_bank, buf_addr, fft_bank, frame_cnt, done and overrun, clear all bank-full flags and the busy flag, and enter STREAM.
REQ-029 SHALL, when reset is asserted mid-frame, discard all partial and pending frames; the first fir_valid after release writes bank 0, address 0.

Configuration
REQ-030 SHALL, with FAS_CTRL_ANALYSIS_EN defined, go from STREAM to ANALYZE, pulse ana_start on the first ANALYZE cycle, wait for ana_done, then enter FINISH with done=1 on the next edge.
REQ-031 SHALL, without FAS_CTRL_ANALYSIS_EN, tie ana_start to 0, ignore ana_done, and go from STREAM directly to FINISH with done=1 the cycle after the last fft_valid.

Verification
REQ-032 SHALL be verified by: 16 back-to-back fir_valid -> buf_addr 0..15 on bank 0, then fft_start=1 with fft_bank=0 one cycle after the 16th write, and buf_bank=1.
REQ-033 SHALL be verified by: fft_done 40 cycles after fft_start -> fft_valid pulses exactly one cycle later and frame_cnt goes 0->1.
REQ-034 SHALL be verified by: FFT held busy while 33 samples arrive -> samples 1-32 are written, sample 33 is dropped with overrun=1 and buf_addr unchanged.
REQ-035 SHALL be verified by: NUM_FRAMES=64, 1024 continuous samples, FFT latency 20, ana_done 5 cycles after ana_start, FAS_CTRL_ANALYSIS_EN defined -> 64 fft_valid pulses, one ana_start, done=1, overrun=0.
REQ-036 SHALL be verified by: the same run without the macro -> ana_start never pulses and done=1 one cycle after the 64th fft_valid.
REQ-037 SHALL be verified by: rst asserted after 7 samples of frame 3 -> all outputs 0 immediately, and the next sample writes bank 0, address 0.
